// File: rtl/fir_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer_if
// Description : Bundle between the FIR MAC sequencer and the rest of the filter
//               (sample strobe in, delay-line/ROM/MAC control out).
// Revision    : 1.0 - initial release
// ============================================================================
interface fir_mac_sequencer_if #(
    parameter int AW = 7
);
    logic          sam_clk_en;
    logic          clr_overrun;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] tap_a_addr;
    logic [AW-1:0] tap_b_addr;
    logic [AW-1:0] coef_addr;
    logic          pre_add_en;
    logic          acc_clr;
    logic          acc_en;
    logic          out_load;
    logic          busy;
    logic          overrun;

    modport master (
        output sam_clk_en, clr_overrun,
        input  wr_en, wr_addr, tap_a_addr, tap_b_addr, coef_addr,
        input  pre_add_en, acc_clr, acc_en, out_load, busy, overrun
    );

    modport slave (
        input  sam_clk_en, clr_overrun,
        output wr_en, wr_addr, tap_a_addr, tap_b_addr, coef_addr,
        output pre_add_en, acc_clr, acc_en, out_load, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer
// Description : Time-multiplexed FIR controller: delay-line write, tap/coef
//               address sequencing, MAC strobes, drain and output load.
//               Define MAC_SEQ_FOLD_EN for symmetric (pre-added) folding.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int NTAPS = 101,
    parameter int PIPE  = 2,
    parameter int AW    = $clog2(NTAPS)
) (
    input  wire logic           sys_clk,
    input  wire logic           reset,
    fir_mac_sequencer_if.slave  bus
);

`ifdef MAC_SEQ_FOLD_EN
    localparam int              c_h      = (NTAPS - 1) / 2;
    localparam int              c_last   = c_h;
    localparam logic [AW-1:0]   c_h_j    = AW'(c_h);
`else
    localparam int              c_last   = NTAPS - 1;
`endif
    localparam logic [AW-1:0]   c_last_j = AW'(c_last);
    localparam logic [AW:0]     c_ntaps  = (AW+1)'(NTAPS);
    localparam int              c_dw     = (PIPE > 1) ? $clog2(PIPE) : 1;
    localparam int              c_dlast  = (PIPE > 0) ? PIPE - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_j;
    logic [c_dw-1:0] r_drain;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [AW-1:0]   r_tap_a;
    logic [AW-1:0]   r_tap_b;
    logic [AW-1:0]   r_coef;
    logic            r_pre_add;
    logic            r_acc_clr;
    logic            r_acc_en;
    logic            r_out_load;
    logic            r_busy;
    logic            r_overrun;

    logic [AW-1:0]   w_j_next;
    logic [AW:0]     w_sum_a;
    logic [AW-1:0]   w_addr_a;
    logic [AW-1:0]   w_head_dec;
`ifdef MAC_SEQ_FOLD_EN
    logic [AW:0]     w_sum_b;
    logic [AW-1:0]   w_addr_b;
`endif

    // Addresses are precomputed for the tap about to be issued so they can be registered.
    always_comb begin
        w_j_next   = (r_state == S_WRITE) ? '0 : r_j + 1'b1;
        w_sum_a    = {1'b0, r_head} + {1'b0, w_j_next};
        w_addr_a   = AW'((w_sum_a >= c_ntaps) ? (w_sum_a - c_ntaps) : w_sum_a);
        w_head_dec = (r_head == '0) ? AW'(NTAPS - 1) : r_head - 1'b1;
`ifdef MAC_SEQ_FOLD_EN
        w_sum_b    = {1'b0, r_head} + (c_ntaps - 1'b1 - {1'b0, w_j_next});
        w_addr_b   = AW'((w_sum_b >= c_ntaps) ? (w_sum_b - c_ntaps) : w_sum_b);
`endif
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_head     <= '0;
            r_j        <= '0;
            r_drain    <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_tap_a    <= '0;
            r_tap_b    <= '0;
            r_coef     <= '0;
            r_pre_add  <= 1'b0;
            r_acc_clr  <= 1'b0;
            r_acc_en   <= 1'b0;
            r_out_load <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (bus.sam_clk_en && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_overrun) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.sam_clk_en) begin
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_head;
                        r_busy    <= 1'b1;
                    end
                end

                S_WRITE, S_MAC: begin
                    if ((r_state == S_MAC) && (r_j == c_last_j)) begin
                        r_acc_en  <= 1'b0;
                        r_acc_clr <= 1'b0;
                        r_pre_add <= 1'b0;
                        r_tap_a   <= '0;
                        r_tap_b   <= '0;
                        r_coef    <= '0;
                        if (PIPE > 0) begin
                            r_state <= S_DRAIN;
                            r_drain <= '0;
                        end else begin
                            r_state    <= S_DONE;
                            r_out_load <= 1'b1;
                        end
                    end else begin
                        r_state   <= S_MAC;
                        r_wr_en   <= 1'b0;
                        r_wr_addr <= '0;
                        r_j       <= w_j_next;
                        r_acc_en  <= 1'b1;
                        r_acc_clr <= (r_state == S_WRITE);
                        r_coef    <= w_j_next;
                        r_tap_a   <= w_addr_a;
`ifdef MAC_SEQ_FOLD_EN
                        // Center tap has no mirror partner.
                        if (w_j_next == c_h_j) begin
                            r_tap_b   <= '0;
                            r_pre_add <= 1'b0;
                        end else begin
                            r_tap_b   <= w_addr_b;
                            r_pre_add <= 1'b1;
                        end
`else
                        r_tap_b   <= '0;
                        r_pre_add <= 1'b0;
`endif
                    end
                end

                S_DRAIN: begin
                    if (r_drain == c_dw'(c_dlast)) begin
                        r_state    <= S_DONE;
                        r_out_load <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end

                S_DONE: begin
                    r_out_load <= 1'b0;
                    r_busy     <= 1'b0;
                    r_head     <= w_head_dec;
                    r_j        <= '0;
                    r_state    <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.tap_a_addr = r_tap_a;
    assign bus.tap_b_addr = r_tap_b;
    assign bus.coef_addr  = r_coef;
    assign bus.pre_add_en = r_pre_add;
    assign bus.acc_clr    = r_acc_clr;
    assign bus.acc_en     = r_acc_en;
    assign bus.out_load   = r_out_load;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Self-checking bench for fir_mac_sequencer (directed table,
//               async-reset sequence, randomized strobes vs timeline model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int N    = 101;
    localparam int PIPE = 2;
    localparam int AW   = $clog2(N);
    localparam int H    = (N - 1) / 2;
`ifdef MAC_SEQ_FOLD_EN
    localparam bit FOLD = 1'b1;
    localparam int L    = H + 1;
`else
    localparam bit FOLD = 1'b0;
    localparam int L    = N;
`endif
    localparam int TLOAD = L + 2 + PIPE;

    typedef struct packed {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [AW-1:0] ta;
        logic [AW-1:0] tb;
        logic [AW-1:0] coef;
        logic          pre;
        logic          aclr;
        logic          acc;
        logic          load;
        logic          busy;
        logic          ovr;
    } outs_t;

    typedef struct {
        int    cyc;
        logic  sam;
        logic  clr;
        outs_t exp;
    } vec_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;

    // timeline model: position within the accepted sequence
    bit   m_active = 1'b0;
    int   m_t      = 0;
    int   m_head   = 0;
    bit   m_ovr    = 1'b0;

    fir_mac_sequencer_if #(.AW(AW)) bus ();

    fir_mac_sequencer #(.NTAPS(N), .PIPE(PIPE), .AW(AW)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic outs_t dut_outs();
        outs_t o;
        o.wr_en   = bus.wr_en;
        o.wr_addr = bus.wr_addr;
        o.ta      = bus.tap_a_addr;
        o.tb      = bus.tap_b_addr;
        o.coef    = bus.coef_addr;
        o.pre     = bus.pre_add_en;
        o.aclr    = bus.acc_clr;
        o.acc     = bus.acc_en;
        o.load    = bus.out_load;
        o.busy    = bus.busy;
        o.ovr     = bus.overrun;
        return o;
    endfunction

    // Addresses only matter while their strobe is active.
    function automatic outs_t msk(input outs_t i);
        outs_t o = i;
        if (!o.wr_en) o.wr_addr = '0;
        if (!o.acc) begin
            o.ta = '0; o.tb = '0; o.coef = '0; o.pre = 1'b0;
        end
        return o;
    endfunction

    function automatic outs_t mk(input int wr, input int wa, input int ta, input int tb,
                                 input int coef, input int pre, input int aclr, input int acc,
                                 input int load, input int busy, input int ovr);
        outs_t o;
        o.wr_en = 1'(wr);  o.wr_addr = AW'(wa); o.ta = AW'(ta); o.tb = AW'(tb);
        o.coef = AW'(coef); o.pre = 1'(pre); o.aclr = 1'(aclr); o.acc = 1'(acc);
        o.load = 1'(load); o.busy = 1'(busy); o.ovr = 1'(ovr);
        return o;
    endfunction

    function automatic outs_t model_exp();
        outs_t o = '0;
        int j;
        o.ovr = m_ovr;
        if (m_active) begin
            o.busy = 1'b1;
            if (m_t == 1) begin
                o.wr_en = 1'b1; o.wr_addr = AW'(m_head);
            end else if (m_t >= 2 && m_t <= L + 1) begin
                j = m_t - 2;
                o.acc = 1'b1; o.aclr = (j == 0); o.coef = AW'(j);
                o.ta = AW'((m_head + j) % N);
                if (FOLD && j < H) begin
                    o.tb = AW'((m_head + N - 1 - j) % N); o.pre = 1'b1;
                end
            end else if (m_t == TLOAD) begin
                o.load = 1'b1;
            end
        end
        return o;
    endfunction

    task automatic model_advance(input logic s, input logic c);
        if (s && m_active)  m_ovr = 1'b1;
        else if (c)         m_ovr = 1'b0;
        if (m_active) begin
            if (m_t == TLOAD) begin
                m_active = 1'b0;
                m_head   = (m_head + N - 1) % N;
            end else begin
                m_t++;
            end
        end else if (s) begin
            m_active = 1'b1;
            m_t      = 1;
        end
    endtask

    task automatic check(input string name, input outs_t exp, input bit masked);
        outs_t got = dut_outs();
        outs_t g   = masked ? msk(got) : got;
        outs_t e   = masked ? msk(exp) : exp;
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, g, e);
        end
    endtask

    task automatic step(input logic s, input logic c);
        @(posedge sys_clk);
        #1;
        bus.sam_clk_en  = s;
        bus.clr_overrun = c;
        cyc++;
        check("model", model_exp(), 1'b1);
        model_advance(s, c);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        check("reset_async", '0, 1'b0);
        @(posedge sys_clk);
        #1;
        check("reset_hold", '0, 1'b0);
        bus.sam_clk_en  = 1'b0;
        bus.clr_overrun = 1'b0;
        reset    = 1'b0;
        m_active = 1'b0;
        m_t      = 0;
        m_head   = 0;
        m_ovr    = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        int s2;
        int base;
        int fb;
        s2 = L + 5;
        fb = FOLD ? 1 : 0;
        //               cyc          sam  clr      wr wa   ta    tb            coef  pre aclr acc ld bsy ovr
        tbl.push_back('{0,            1'b1, 1'b0, mk(0, 0,   0,    0,            0,    0,  0,   0,  0, 0,  0)});
        tbl.push_back('{1,            1'b0, 1'b0, mk(1, 0,   0,    0,            0,    0,  0,   0,  0, 1,  0)});
        tbl.push_back('{2,            1'b0, 1'b0, mk(0, 0,   0,    FOLD?100:0,   0,    fb, 1,   1,  0, 1,  0)});
        tbl.push_back('{3,            1'b0, 1'b0, mk(0, 0,   1,    FOLD?99:0,    1,    fb, 0,   1,  0, 1,  0)});
        tbl.push_back('{L + 1,        1'b0, 1'b0, mk(0, 0,   L-1,  0,            L-1,  0,  0,   1,  0, 1,  0)});
        tbl.push_back('{L + 2,        1'b0, 1'b0, mk(0, 0,   0,    0,            0,    0,  0,   0,  0, 1,  0)});
        tbl.push_back('{TLOAD,        1'b0, 1'b0, mk(0, 0,   0,    0,            0,    0,  0,   0,  1, 1,  0)});
        tbl.push_back('{s2,           1'b1, 1'b0, mk(0, 0,   0,    0,            0,    0,  0,   0,  0, 0,  0)});
        tbl.push_back('{s2 + 1,       1'b0, 1'b0, mk(1, 100, 0,    0,            0,    0,  0,   0,  0, 1,  0)});
        tbl.push_back('{s2 + 2,       1'b0, 1'b0, mk(0, 0,   100,  FOLD?99:0,    0,    fb, 1,   1,  0, 1,  0)});
        tbl.push_back('{s2 + 30,      1'b1, 1'b0, mk(0, 0,   27,   FOLD?71:0,    28,   fb, 0,   1,  0, 1,  0)});
        tbl.push_back('{s2 + 31,      1'b0, 1'b0, mk(0, 0,   28,   FOLD?70:0,    29,   fb, 0,   1,  0, 1,  1)});
        tbl.push_back('{s2 + 34,      1'b1, 1'b1, mk(0, 0,   31,   FOLD?67:0,    32,   fb, 0,   1,  0, 1,  1)});
        tbl.push_back('{s2 + 35,      1'b0, 1'b0, mk(0, 0,   32,   FOLD?66:0,    33,   fb, 0,   1,  0, 1,  1)});
        tbl.push_back('{s2 + 36,      1'b0, 1'b1, mk(0, 0,   33,   FOLD?65:0,    34,   fb, 0,   1,  0, 1,  1)});
        tbl.push_back('{s2 + 37,      1'b0, 1'b0, mk(0, 0,   34,   FOLD?64:0,    35,   fb, 0,   1,  0, 1,  0)});
        tbl.push_back('{s2 + TLOAD,   1'b0, 1'b0, mk(0, 0,   0,    0,            0,    0,  0,   0,  1, 1,  0)});
        tbl.push_back('{s2 + TLOAD+1, 1'b0, 1'b0, mk(0, 0,   0,    0,            0,    0,  0,   0,  0, 0,  0)});

        bus.sam_clk_en  = 1'b0;
        bus.clr_overrun = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        do_reset();

        // Directed table from a fresh reset
        base = cyc + 1;
        for (int i = 0; i < tbl.size(); i++) begin
            while (cyc < base + tbl[i].cyc - 1) step(1'b0, 1'b0);
            step(tbl[i].sam, tbl[i].clr);
            check("table", tbl[i].exp, 1'b1);
        end
        repeat (5) step(1'b0, 1'b0);

        // Async reset in cycle 20 abandons the sequence; next strobe restarts at head 0
        step(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) step(1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < TLOAD + 4; k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("restart_write", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1'b1);
        step(1'b0, 1'b0);
        check("restart_mac0", mk(0, 0, 0, FOLD?100:0, 0, fb, 1, 1, 0, 1, 0), 1'b1);

        // Randomized strobes, clears and occasional resets against the timeline model
        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
            if ($urandom_range(0, 1499) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
